logic_op_bist: RTL and testbench

- Self-test initiator for the two-input logical-operations unit: drives a_out/b_out into the unit and samples its AND, OR and NOT-a results on y1_in/y2_in/y3_in.
- On start, walks all four input vectors, waits a settle time, compares each result with the expected value and reports pass/fail with per-vector failure flags.
- Sits beside the logical-operations unit in the combinational-circuits test fabric and is driven by a top-level controller or bench.

---
 rtl/logic_op_pkg.sv | 23 ++
 rtl/logic_op_expected.sv | 15 +
 rtl/logic_op_bist.sv | 122 ++++++++++++
 tb/tb_logic_op_bist.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared types and golden function for the logic-op unit
// and its self-test initiator.
package logic_op_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 4;

  // Packed as {y3, y2, y1} = {~a, a|b, a&b}.
  function automatic logic [2:0] exp_y(
    input logic a,
    input logic b
  );
    return {~a, a | b, a & b};
  endfunction

endpackage

// File: rtl/logic_op_expected.sv
// Combinational golden model of the logic-op unit.
// Maps {a,b} to the expected AND / OR / NOT-a results.
module logic_op_expected
  import logic_op_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y1,
  output logic y2,
  output logic y3
);

  assign {y3, y2, y1} = exp_y(a, b);

endmodule

// File: rtl/logic_op_bist.sv
// Self-test initiator for the two-input logic-op unit.
// Walks all four vectors and records per-vector failures.
module logic_op_bist
  import logic_op_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  output logic       a_out,
  output logic       b_out,
  input  logic       y1_in,
  input  logic       y2_in,
  input  logic       y3_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       pass_out,
  output logic [2:0] err_count_out,
  output logic [3:0] fail_vec_out
);

  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX =
    2'(NUM_VECTORS - 1);
  localparam logic [2:0] ERR_MAX =
    3'(NUM_VECTORS);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic       exp_y1;
  logic       exp_y2;
  logic       exp_y3;
  logic       mismatch;
  logic [2:0] err_next;

  logic_op_expected u_exp (
    .a  (idx[1]),
    .b  (idx[0]),
    .y1 (exp_y1),
    .y2 (exp_y2),
    .y3 (exp_y3)
  );

  assign mismatch =
    {y1_in, y2_in, y3_in} != {exp_y1, exp_y2, exp_y3};

  // Saturating so the count can never wrap past NUM_VECTORS.
  assign err_next =
    (mismatch && err_count_out != ERR_MAX)
      ? err_count_out + 3'd1
      : err_count_out;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      a_out         <= 1'b0;
      b_out         <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      pass_out      <= 1'b0;
      err_count_out <= '0;
      fail_vec_out  <= '0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            pass_out      <= 1'b0;
            err_count_out <= '0;
            fail_vec_out  <= '0;
            idx           <= '0;
            busy_out      <= 1'b1;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          {a_out, b_out} <= idx;
          cnt            <= SETTLE_LD;
          state          <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            fail_vec_out[idx] <= 1'b1;
            err_count_out     <= err_next;
          end
          if (idx == LAST_IDX) begin
            done_out <= 1'b1;
            pass_out <= (err_next == 3'd0);
            busy_out <= 1'b0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            state    <= DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_bist.sv
// Scoreboard bench for logic_op_bist driving a fault-injectable
// model of the logic-op unit.
module tb_logic_op_bist;

  localparam int SETTLE = 2;
  localparam int LAT    = 4 * (SETTLE + 2);

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       start_in = 1'b0;
  logic       a_out;
  logic       b_out;
  logic       y1_in;
  logic       y2_in;
  logic       y3_in;
  logic       busy_out;
  logic       done_out;
  logic       pass_out;
  logic [2:0] err_count_out;
  logic [3:0] fail_vec_out;

  // Fault masks on {y3,y2,y1}: invert, stuck-at-0, stuck-at-1.
  logic [2:0] inv = '0;
  logic [2:0] s0  = '0;
  logic [2:0] s1  = '0;
  logic [2:0] good;
  logic [2:0] act;

  assign good = {~a_out, a_out | b_out, a_out & b_out};
  assign act  = ((good ^ inv) & ~s0) | s1;
  assign y1_in = act[0];
  assign y2_in = act[1];
  assign y3_in = act[2];

  logic_op_bist #(
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (4)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .a_out         (a_out),
    .b_out         (b_out),
    .y1_in         (y1_in),
    .y2_in         (y2_in),
    .y3_in         (y3_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .pass_out      (pass_out),
    .err_count_out (err_count_out),
    .fail_vec_out  (fail_vec_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit       pass;
    bit [2:0] err;
    bit [3:0] fvec;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_run = 0;

  task automatic chk(input string name, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic exp_t model(input bit [2:0] fi,
                                 input bit [2:0] f0,
                                 input bit [2:0] f1);
    exp_t     e;
    bit       a;
    bit       b;
    bit [2:0] want;
    bit [2:0] got;
    e.fvec = '0;
    e.err  = '0;
    for (int v = 0; v < 4; v++) begin
      a    = (v >= 2);
      b    = (v % 2 == 1);
      want = {!a, a || b, a && b};
      got  = ((want ^ fi) & ~f0) | f1;
      if (got != want) begin
        e.fvec[v] = 1'b1;
        e.err     = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_n_in) begin
      busy_run = 0;
    end else begin
      if (busy_out) busy_run++;
      if (done_out) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pass", int'(pass_out), int'(e.pass));
          chk("err_count", int'(err_count_out), int'(e.err));
          chk("fail_vec", int'(fail_vec_out), int'(e.fvec));
          chk("busy_cycles", busy_run, LAT);
          chk("ab_idle", int'({a_out, b_out}), 0);
        end
        busy_run = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a"}, int'(a_out), 0);
    chk({tag, "_b"}, int'(b_out), 0);
    chk({tag, "_busy"}, int'(busy_out), 0);
    chk({tag, "_done"}, int'(done_out), 0);
    chk({tag, "_pass"}, int'(pass_out), 0);
    chk({tag, "_err"}, int'(err_count_out), 0);
    chk({tag, "_fvec"}, int'(fail_vec_out), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk_in);
    #1 start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
  endtask

  task automatic run(input bit [2:0] fi, input bit [2:0] f0,
                     input bit [2:0] f1, input bit noisy);
    int d0;
    d0  = done_cnt;
    inv = fi;
    s0  = f0;
    s1  = f1;
    last = model(fi, f0, f1);
    sb.push_back(last);
    pulse_start();
    @(negedge clk_in);
    chk("start_busy", int'(busy_out), 1);
    chk("start_clr_err", int'(err_count_out), 0);
    chk("start_clr_fvec", int'(fail_vec_out), 0);
    chk("start_clr_pass", int'(pass_out), 0);
    if (noisy) begin
      repeat (2) @(posedge clk_in);
      #1 start_in = 1'b1;
      @(posedge clk_in);
      #1 start_in = 1'b0;
      repeat (5) @(posedge clk_in);
      #1 start_in = 1'b1;
      @(posedge clk_in);
      #1 start_in = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != d0) break;
      @(posedge clk_in);
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("hold_pass", int'(pass_out), int'(last.pass));
    chk("hold_err", int'(err_count_out), int'(last.err));
    chk("hold_fvec", int'(fail_vec_out), int'(last.fvec));
    chk("hold_idle", int'(busy_out), 0);
    if (noisy) begin
      repeat (20) @(posedge clk_in);
      chk("single_done", done_cnt, d0 + 1);
    end
  endtask

  task automatic abort_run();
    int d0;
    d0  = done_cnt;
    inv = '0;
    s0  = '0;
    s1  = '0;
    sb.push_back(model('0, '0, '0));
    pulse_start();
    repeat (9) @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("abort");
    sb.delete();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (25) @(posedge clk_in);
    chk("no_done_after_abort", done_cnt, d0);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("reset");
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    run(3'b000, 3'b000, 3'b000, 1'b0);
    run(3'b000, 3'b001, 3'b000, 1'b0);
    run(3'b000, 3'b000, 3'b100, 1'b0);
    run(3'b010, 3'b000, 3'b000, 1'b0);
    run(3'b000, 3'b000, 3'b000, 1'b1);
    abort_run();
    run(3'b000, 3'b000, 3'b000, 1'b0);
    run(3'b111, 3'b000, 3'b000, 1'b0);
    run(3'b000, 3'b000, 3'b000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      run(3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7) & $urandom_range(0, 7)),
          3'($urandom_range(0, 7) & $urandom_range(0, 7)),
          1'b0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
